// File: rtl/framing.sv
// Overlapping frame builder: buffers the sample stream in a circular memory
// and replays FRAME_LEN-sample frames, oldest first, every HOP new samples.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | no frame being read, waiting for a trigger
//   READ  | one memory read per cycle for FRAME_LEN cycles
module framing #(
  parameter int BW        = 9,
  parameter int FRAME_LEN = 256,
  parameter int HOP       = 128
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          en_i,
  input  logic [BW-1:0] data_i,
  input  logic          valid_i,
  output logic [BW-1:0] data_o,
  output logic          valid_o,
  output logic          last_o,
  output logic          overrun_o
);
  localparam int DEPTH = 2 * FRAME_LEN;
  localparam int AW    = $clog2(DEPTH);
  localparam int FW    = $clog2(FRAME_LEN + 1);
  localparam int HW    = (HOP > 1) ? $clog2(HOP) : 1;
  localparam int CW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic {IDLE, READ} state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt, pend_ptr, pend_ptr_nxt, trig_start;
  logic [FW-1:0] fill;
  logic [HW-1:0] hop_cnt;
  logic [CW-1:0] rd_cnt, rd_cnt_nxt;
  logic          pend, pend_nxt, ovr_nxt;
  logic          accept, hop_wrap, fill_done, trigger, rd_last;

  assign accept     = valid_i & en_i;
  assign hop_wrap   = (hop_cnt == HW'(HOP - 1));
  // fill reaches FRAME_LEN on this edge, or already saturated there
  assign fill_done  = (fill == FW'(FRAME_LEN)) || (fill == FW'(FRAME_LEN - 1));
  assign trigger    = accept & fill_done & hop_wrap;
  assign trig_start = wr_ptr + AW'(1) - AW'(FRAME_LEN);
  assign rd_last    = (rd_cnt == CW'(FRAME_LEN - 1));

  always_ff @(posedge clk_i) begin
    if (accept) mem[wr_ptr] <= data_i;
  end

  always_comb begin
    state_nxt    = state;
    rd_ptr_nxt   = rd_ptr;
    rd_cnt_nxt   = rd_cnt;
    pend_nxt     = pend;
    pend_ptr_nxt = pend_ptr;
    // a trigger that finds a frame already queued is lost
    ovr_nxt      = overrun_o | (trigger & pend);
    case (state)
      IDLE: begin
        if (pend) begin
          state_nxt  = READ;
          rd_ptr_nxt = pend_ptr;
          rd_cnt_nxt = '0;
          pend_nxt   = 1'b0;
        end else if (trigger) begin
          state_nxt  = READ;
          rd_ptr_nxt = trig_start;
          rd_cnt_nxt = '0;
        end
      end
      READ: begin
        rd_ptr_nxt = rd_ptr + AW'(1);
        rd_cnt_nxt = rd_cnt + CW'(1);
        if (rd_last) begin
          rd_cnt_nxt = '0;
          if (pend) begin
            rd_ptr_nxt = pend_ptr;
            pend_nxt   = 1'b0;
          end else if (trigger) begin
            rd_ptr_nxt = trig_start;
          end else begin
            state_nxt  = IDLE;
          end
        end else if (trigger && !pend) begin
          pend_nxt     = 1'b1;
          pend_ptr_nxt = trig_start;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pend_ptr  <= '0;
      fill      <= '0;
      hop_cnt   <= '0;
      rd_cnt    <= '0;
      pend      <= 1'b0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      last_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else if (!en_i) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pend_ptr  <= '0;
      fill      <= '0;
      hop_cnt   <= '0;
      rd_cnt    <= '0;
      pend      <= 1'b0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      last_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_ptr    <= rd_ptr_nxt;
      rd_cnt    <= rd_cnt_nxt;
      pend      <= pend_nxt;
      pend_ptr  <= pend_ptr_nxt;
      overrun_o <= ovr_nxt;
      if (accept) begin
        wr_ptr  <= wr_ptr + AW'(1);
        hop_cnt <= hop_wrap ? '0 : hop_cnt + HW'(1);
        if (fill != FW'(FRAME_LEN)) fill <= fill + FW'(1);
      end
      valid_o <= (state == READ);
      last_o  <= (state == READ) && rd_last;
      data_o  <= (state == READ) ? mem[rd_ptr] : '0;
    end
  end

endmodule

// File: tb/tb_framing.sv
// Bench for framing: a sample-queue / frame-schedule model predicts every
// output cycle; directed phases pin a few values by hand, then random traffic.
module tb_framing;
  localparam int BW  = 9;
  localparam int FL  = 256;
  localparam int HOP = 128;

  logic          clk_i = 1'b0;
  logic          rst_n_i, en_i, valid_i;
  logic [BW-1:0] data_i;
  logic [BW-1:0] data_o;
  logic          valid_o, last_o, overrun_o;

  framing #(.BW(BW), .FRAME_LEN(FL), .HOP(HOP)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .data_i(data_i),
    .valid_i(valid_i), .data_o(data_o), .valid_o(valid_o), .last_o(last_o),
    .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every accepted sample in order; each frame is (first read cycle,
  // index of its oldest sample). Output cycles are r+1 .. r+FL.
  typedef struct { int r; int first; } frame_t;
  logic [BW-1:0] samples[$];
  frame_t        frames[$];
  bit            m_ovr;
  int            cyc = 0;

  function automatic void model_clear();
    samples.delete();
    frames.delete();
    m_ovr = 1'b0;
  endfunction

  always @(negedge rst_n_i) model_clear();

  always @(posedge clk_i) begin
    int n, r;
    if (!rst_n_i || !en_i) begin
      model_clear();
    end else if (valid_i) begin
      samples.push_back(data_i);
      n = samples.size();
      if (n >= FL && n % HOP == 0) begin
        if (frames.size() > 0 && frames[$].r > cyc) begin
          m_ovr = 1'b1;
        end else begin
          r = cyc + 1;
          if (frames.size() > 0 && frames[$].r + FL > r) r = frames[$].r + FL;
          frames.push_back('{r: r, first: n - FL});
        end
      end
    end
    cyc++;
  end

  bit            chk_on = 1'b0;
  int            n_valid = 0;
  int            n_last = 0;
  logic [BW-1:0] got[$];
  bit            ev, el;
  logic [BW-1:0] ed;

  always @(negedge clk_i) begin
    if (chk_on) begin
      ev = 1'b0;
      el = 1'b0;
      ed = '0;
      while (frames.size() > 0 && frames[0].r + FL < cyc) void'(frames.pop_front());
      if (frames.size() > 0 && frames[0].r + 1 <= cyc) begin
        ev = 1'b1;
        ed = samples[frames[0].first + cyc - frames[0].r - 1];
        el = (cyc == frames[0].r + FL);
      end
      chk("valid_o", valid_o, ev);
      chk("last_o", last_o, el);
      chk("overrun_o", overrun_o, m_ovr);
      if (ev) chk("data_o", data_o, ed);
      if (valid_o) begin
        n_valid++;
        got.push_back(data_o);
      end
      if (last_o) n_last++;
    end
  end

  task automatic step(input bit v, input logic [BW-1:0] d);
    valid_i = v;
    data_i  = d;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int c0, dens;
    rst_n_i = 1'b0;
    en_i    = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    @(posedge clk_i);
    #1;
    chk_on = 1'b1;
    chk("rst_valid", valid_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_ovr", overrun_o, 0);
    repeat (2) step(0, '0);
    rst_n_i = 1'b1;

    // fill and first frame: ramp, one sample every 4th cycle
    for (int i = 0; i < 255; i++) begin
      step(1, 9'(i));
      repeat (3) step(0, '0);
    end
    chk("no_early_out", n_valid, 0);
    step(1, 9'd255);
    valid_i = 1'b0;
    @(negedge clk_i);
    chk("lat_t1", valid_o, 0);
    @(negedge clk_i);
    chk("lat_t2", valid_o, 1);
    chk("first_data", data_o, 0);

    // hop frames with ring wrap-around
    for (int i = 256; i < 512; i++) begin
      step(1, 9'(i));
      repeat (3) step(0, '0);
    end
    repeat (300) step(0, '0);
    chk("hop_n_last", n_last, 3);
    chk("hop_n_valid", n_valid, 768);
    chk("f1_last", got[255], 9'h0ff);
    chk("f2_first", got[256], 9'd128);
    chk("f3_first", got[512], 9'h100);
    chk("f3_last", got[767], 9'h1ff);

    // sign extremes
    for (int i = 0; i < 256; i++) begin
      step(1, (i % 2 != 0) ? 9'h0ff : 9'h100);
      step(0, '0);
    end
    repeat (300) step(0, '0);
    chk("sign_last", got[got.size()-1], 9'h0ff);
    chk("sign_prev", got[got.size()-2], 9'h100);

    // continuous input from a clean start: pending frame then overrun
    en_i = 1'b0;
    step(1, 9'd5);
    en_i = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (i == 511) chk("ovr_before", overrun_o, 0);
      if (i == 512) chk("ovr_set", overrun_o, 1);
      step(1, 9'($urandom));
    end
    chk("ovr_sticky", overrun_o, 1);

    // one-cycle disable mid-stream
    en_i = 1'b0;
    step(1, 9'($urandom));
    en_i = 1'b1;
    chk("dis_ovr", overrun_o, 0);
    chk("dis_valid", valid_o, 0);

    // reset around frame sample 100
    for (int i = 0; i < 357; i++) step(1, 9'($urandom));
    #2;
    chk("pre_rst_busy", valid_o, 1);
    rst_n_i = 1'b0;
    #1;
    chk("arst_valid", valid_o, 0);
    chk("arst_last", last_o, 0);
    chk("arst_data", data_o, 0);
    repeat (3) step(0, '0);
    rst_n_i = 1'b1;
    for (int i = 0; i < 255; i++) step(1, 9'($urandom));
    c0 = n_valid;
    repeat (5) step(0, '0);
    chk("post_rst_wait", n_valid, c0);
    step(1, 9'($urandom));
    valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("post_rst_frame", valid_o, 1);
    repeat (300) step(0, '0);

    // random traffic with occasional disables
    dens = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) dens = $urandom_range(1, 100);
      en_i = ($urandom_range(0, 799) != 0);
      step($urandom_range(0, 99) < dens, 9'($urandom));
    end
    en_i = 1'b1;
    repeat (600) step(0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
